// File: rtl/gate_seq_pkg.sv
// Shared types and constants for the gate sequencer: gate states, LED bit map,
// and small helpers for state stepping and one-hot select decoding.
package gate_seq_pkg;

   typedef enum logic [1:0] {
      S_AND = 2'd0,
      S_OR  = 2'd1,
      S_XOR = 2'd2,
      S_NOT = 2'd3
   } gate_state_t;

   localparam int NUM_GATES = 4;

   localparam int LED_AND  = 0;
   localparam int LED_OR   = 2;
   localparam int LED_XOR  = 4;
   localparam int LED_NOTA = 6;
   localparam int LED_NOTB = 7;

   // Wraps naturally because the state is exactly two bits wide.
   function automatic gate_state_t next_gate(input gate_state_t s, input logic rev);
      logic [1:0] n;
      n = rev ? (s - 2'd1) : (s + 2'd1);
      return gate_state_t'(n);
   endfunction

   function automatic logic [NUM_GATES-1:0] gate_onehot(input gate_state_t s);
      logic [NUM_GATES-1:0] v;
      v    = '0;
      v[s] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/and_gate.sv
// Two-input AND gate cell.
module and_gate (
   input  logic a,
   input  logic b,
   output logic y
);
   assign y = a & b;
endmodule

// File: rtl/key_debounce.sv
// Active-low pushbutton conditioner: 2-flop synchroniser, stability counter and a
// one-cycle press_pulse when the debounced level falls. Releases give no event.
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_n,
   output logic press_pulse
);

   localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [1:0]    sync;
   logic          level;
   logic [CW-1:0] cnt;

   // The counter only runs while the synced input disagrees with the accepted
   // level; any bounce back to the accepted level throws the progress away.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync        <= 2'b11;
         level       <= 1'b1;
         cnt         <= '0;
         press_pulse <= 1'b0;
      end else begin
         sync        <= {sync[0], key_n};
         press_pulse <= 1'b0;
         if (sync[1] == level) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            level       <= sync[1];
            cnt         <= '0;
            press_pulse <= ~sync[1];
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/not_gate.sv
// Inverter cell.
module not_gate (
   input  logic a,
   output logic y
);
   assign y = ~a;
endmodule

// File: rtl/or_gate.sv
// Two-input OR gate cell.
module or_gate (
   input  logic a,
   input  logic b,
   output logic y
);
   assign y = a | b;
endmodule

// File: rtl/xor_gate.sv
// Two-input XOR gate cell.
module xor_gate (
   input  logic a,
   input  logic b,
   output logic y
);
   assign y = a ^ b;
endmodule

// File: rtl/gate_sequencer.sv
// Time-shares the AND/OR/XOR/NOT gates onto one display path, stepping on a
// debounced STEP press or a dwell timer. GATE_SEQ_REVERSE_EN adds a DIR input.
module gate_sequencer
   import gate_seq_pkg::*;
#(
   parameter int DWELL_CYCLES    = 50000000,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic       CLOCK_50,
   input  logic       RESET_N,
   input  logic [1:0] SW,
   input  logic       STEP_N,
   input  logic       AUTO,
`ifdef GATE_SEQ_REVERSE_EN
   input  logic       DIR,
`endif
   output logic [3:0] GATE_SEL,
   output logic [1:0] RESULT,
   output logic [7:0] LEDG,
   output logic       STEP_PULSE
);

   localparam int DW = (DWELL_CYCLES > 2) ? $clog2(DWELL_CYCLES) : 1;
   localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);

   logic [1:0]    auto_sync;
   logic [1:0]    sw_meta, sw_sync;
   logic          press;
   logic          rev;
   logic          advance;
   logic [DW-1:0] dwell;
   gate_state_t   state, next_state;
   logic          and_y, or_y, xor_y, nota_y, notb_y;
   logic [1:0]    result_d;
   logic [7:0]    ledg_d;

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step (
      .clk         (CLOCK_50),
      .rst_n       (RESET_N),
      .key_n       (STEP_N),
      .press_pulse (press)
   );

`ifdef GATE_SEQ_REVERSE_EN
   logic [1:0] dir_sync;
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) dir_sync <= 2'b00;
      else          dir_sync <= {dir_sync[0], DIR};
   end
   assign rev = dir_sync[1];
`else
   assign rev = 1'b0;
`endif

   and_gate u_and  (.a(sw_sync[0]), .b(sw_sync[1]), .y(and_y));
   or_gate  u_or   (.a(sw_sync[0]), .b(sw_sync[1]), .y(or_y));
   xor_gate u_xor  (.a(sw_sync[0]), .b(sw_sync[1]), .y(xor_y));
   not_gate u_nota (.a(sw_sync[0]), .y(nota_y));
   not_gate u_notb (.a(sw_sync[1]), .y(notb_y));

   // A press and a dwell expiry in the same cycle collapse into one advance.
   assign advance    = press | (auto_sync[1] & (dwell == DWELL_LAST));
   assign next_state = advance ? next_gate(state, rev) : state;

   always_comb begin
      result_d = 2'b00;
      ledg_d   = 8'h00;
      case (next_state)
         S_AND: begin result_d[0] = and_y; ledg_d[LED_AND] = and_y; end
         S_OR:  begin result_d[0] = or_y;  ledg_d[LED_OR]  = or_y;  end
         S_XOR: begin result_d[0] = xor_y; ledg_d[LED_XOR] = xor_y; end
         S_NOT: begin
            result_d         = {notb_y, nota_y};
            ledg_d[LED_NOTA] = nota_y;
            ledg_d[LED_NOTB] = notb_y;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         auto_sync  <= 2'b00;
         sw_meta    <= 2'b00;
         sw_sync    <= 2'b00;
         dwell      <= '0;
         state      <= S_AND;
         GATE_SEL   <= 4'b0001;
         RESULT     <= 2'b00;
         LEDG       <= 8'h00;
         STEP_PULSE <= 1'b0;
      end else begin
         auto_sync  <= {auto_sync[0], AUTO};
         sw_meta    <= SW;
         sw_sync    <= sw_meta;
         dwell      <= (advance || !auto_sync[1]) ? '0 : dwell + 1'b1;
         state      <= next_state;
         GATE_SEL   <= gate_onehot(next_state);
         RESULT     <= result_d;
         LEDG       <= ledg_d;
         STEP_PULSE <= advance;
      end
   end

endmodule

// File: tb/tb_gate_sequencer.sv
// Directed bench for gate_sequencer with short dwell/debounce; define
// GATE_SEQ_REVERSE_EN on both RTL and bench to cover the DIR input.
module tb_gate_sequencer;

   logic       CLOCK_50 = 1'b0;
   logic       RESET_N  = 1'b0;
   logic [1:0] SW       = 2'b00;
   logic       STEP_N   = 1'b1;
   logic       AUTO     = 1'b0;
`ifdef GATE_SEQ_REVERSE_EN
   logic       DIR      = 1'b0;
`endif
   logic [3:0] GATE_SEL;
   logic [1:0] RESULT;
   logic [7:0] LEDG;
   logic       STEP_PULSE;

   int checks      = 0;
   int failures    = 0;
   int cyc         = 0;
   int pulse_total = 0;
   int last_pulse  = 0;

   gate_sequencer #(.DWELL_CYCLES(20), .DEBOUNCE_CYCLES(4)) dut (
      .CLOCK_50   (CLOCK_50),
      .RESET_N    (RESET_N),
      .SW         (SW),
      .STEP_N     (STEP_N),
      .AUTO       (AUTO),
`ifdef GATE_SEQ_REVERSE_EN
      .DIR        (DIR),
`endif
      .GATE_SEL   (GATE_SEL),
      .RESULT     (RESULT),
      .LEDG       (LEDG),
      .STEP_PULSE (STEP_PULSE)
   );

   // clock / cycle counter / strobe counter
   always #5 CLOCK_50 = ~CLOCK_50;
   always @(posedge CLOCK_50) cyc <= cyc + 1;
   always @(posedge CLOCK_50) if (STEP_PULSE === 1'b1) pulse_total <= pulse_total + 1;

   task automatic tick(input int n);
      repeat (n) @(negedge CLOCK_50);
   endtask

   task automatic press();
      STEP_N = 1'b0;
      tick(10);
      STEP_N = 1'b1;
      tick(10);
   endtask

   task automatic wait_pulse(output int at, input int bound);
      at = -1;
      for (int i = 0; i < bound; i++) begin
         @(negedge CLOCK_50);
         if (STEP_PULSE === 1'b1) begin
            at = cyc;
            break;
         end
      end
      checks++;
      if (at < 0) begin
         failures++;
         $display("FAIL pulse_timeout: no STEP_PULSE within %0d cycles, required one", bound);
      end
   endtask

   task automatic test_reset();
      RESET_N = 1'b0; SW = 2'b11; AUTO = 1'b1;
      tick(3);
      RESET_N = 1'b1;
      tick(30);
      @(negedge CLOCK_50);
      #2 RESET_N = 1'b0;
      #1;
      checks++;
      if (GATE_SEL !== 4'b0001) begin failures++; $display("FAIL reset_sel: got %b required 0001", GATE_SEL); end
      checks++;
      if (LEDG !== 8'h00) begin failures++; $display("FAIL reset_ledg: got %h required 00", LEDG); end
      checks++;
      if (RESULT !== 2'b00) begin failures++; $display("FAIL reset_result: got %b required 00", RESULT); end
      checks++;
      if (STEP_PULSE !== 1'b0) begin failures++; $display("FAIL reset_pulse: got %b required 0", STEP_PULSE); end
      SW = 2'b00; AUTO = 1'b0;
      tick(3);
      RESET_N = 1'b1;
      tick(5);
      checks++;
      if (GATE_SEL !== 4'b0001) begin failures++; $display("FAIL post_reset_sel: got %b required 0001", GATE_SEL); end
      SW = 2'b11;
      tick(2);
      checks++;
      if (LEDG !== 8'h00) begin failures++; $display("FAIL sw_latency_early: got %h required 00", LEDG); end
      tick(1);
      checks++;
      if (LEDG !== 8'h01) begin failures++; $display("FAIL sw_latency_ledg: got %h required 01", LEDG); end
      checks++;
      if (RESULT !== 2'b01) begin failures++; $display("FAIL sw_latency_result: got %b required 01", RESULT); end
   endtask

   task automatic test_manual();
      logic [3:0] exp_sel [5];
      int base;
      exp_sel = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
      base = pulse_total;
      for (int i = 0; i < 5; i++) begin
         press();
         checks++;
         if (GATE_SEL !== exp_sel[i]) begin
            failures++;
            $display("FAIL manual_sel%0d: got %b required %b", i, GATE_SEL, exp_sel[i]);
         end
      end
      checks++;
      if (pulse_total - base !== 5) begin
         failures++;
         $display("FAIL manual_pulses: got %0d required 5", pulse_total - base);
      end
   endtask

   task automatic test_bounce();
      int base;
      base = pulse_total;
      for (int i = 0; i < 15; i++) begin
         STEP_N = ~STEP_N;
         tick(2);
      end
      STEP_N = 1'b0;
      tick(10);
      checks++;
      if (pulse_total - base !== 1) begin failures++; $display("FAIL bounce_pulses: got %0d required 1", pulse_total - base); end
      checks++;
      if (GATE_SEL !== 4'b0100) begin failures++; $display("FAIL bounce_sel: got %b required 0100", GATE_SEL); end
      tick(200);
      checks++;
      if (pulse_total - base !== 1) begin failures++; $display("FAIL hold_pulses: got %0d required 1", pulse_total - base); end
      STEP_N = 1'b1;
      tick(10);
      checks++;
      if (pulse_total - base !== 1) begin failures++; $display("FAIL release_pulses: got %0d required 1", pulse_total - base); end
      checks++;
      if (GATE_SEL !== 4'b0100) begin failures++; $display("FAIL release_sel: got %b required 0100", GATE_SEL); end
   endtask

   task automatic test_auto_dwell();
      logic [3:0] exp_sel  [5];
      logic [7:0] exp_ledg [5];
      logic [1:0] exp_res  [5];
      int at;
      int prev;
      exp_sel  = '{4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
      exp_ledg = '{8'h80, 8'h00, 8'h04, 8'h10, 8'h80};
      exp_res  = '{2'b10, 2'b00, 2'b01, 2'b01, 2'b10};
      prev = 0;
      SW = 2'b01;
      AUTO = 1'b1;
      for (int i = 0; i < 5; i++) begin
         wait_pulse(at, 60);
         checks++;
         if (GATE_SEL !== exp_sel[i]) begin failures++; $display("FAIL auto_sel%0d: got %b required %b", i, GATE_SEL, exp_sel[i]); end
         checks++;
         if (LEDG !== exp_ledg[i]) begin failures++; $display("FAIL auto_ledg%0d: got %h required %h", i, LEDG, exp_ledg[i]); end
         checks++;
         if (RESULT !== exp_res[i]) begin failures++; $display("FAIL auto_result%0d: got %b required %b", i, RESULT, exp_res[i]); end
         if (i > 0) begin
            checks++;
            if (at - prev !== 20) begin failures++; $display("FAIL auto_interval%0d: got %0d required 20", i, at - prev); end
         end
         prev = at;
      end
      last_pulse = prev;
   endtask

   task automatic test_simultaneous();
      int at;
      int at2;
      tick(13);
      STEP_N = 1'b0;
      wait_pulse(at, 30);
      STEP_N = 1'b1;
      checks++;
      if (at - last_pulse !== 20) begin failures++; $display("FAIL simul_interval: got %0d required 20", at - last_pulse); end
      checks++;
      if (GATE_SEL !== 4'b0001) begin failures++; $display("FAIL simul_sel: got %b required 0001", GATE_SEL); end
      wait_pulse(at2, 30);
      checks++;
      if (at2 - at !== 20) begin failures++; $display("FAIL simul_restart: got %0d required 20", at2 - at); end
      checks++;
      if (GATE_SEL !== 4'b0010) begin failures++; $display("FAIL simul_next_sel: got %b required 0010", GATE_SEL); end
      AUTO = 1'b0;
      tick(5);
   endtask

`ifdef GATE_SEQ_REVERSE_EN
   task automatic test_reverse();
      RESET_N = 1'b0;
      tick(2);
      RESET_N = 1'b1;
      DIR = 1'b1;
      tick(3);
      press();
      checks++;
      if (GATE_SEL !== 4'b1000) begin failures++; $display("FAIL reverse_sel1: got %b required 1000", GATE_SEL); end
      press();
      checks++;
      if (GATE_SEL !== 4'b0100) begin failures++; $display("FAIL reverse_sel2: got %b required 0100", GATE_SEL); end
      DIR = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_manual();
      test_bounce();
      test_auto_dwell();
      test_simultaneous();
`ifdef GATE_SEQ_REVERSE_EN
      test_reverse();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
